// File: rtl/game_flow_ctl.sv
// Purpose : air-hockey match sequencer (idle -> serve -> play -> goal -> over), paced in video frames.
// Latency : start press acts 3 cycles after the raw button rises; frame tick 2 cycles after vblnk rises.
// Backpr. : none; presses outside IDLE/OVER and score changes outside PLAY are dropped, not queued.
//
// Ports:
//   clk_in          65 MHz pixel clock
//   rst             asynchronous active-high reset
//   vblnk_in        vertical blank; each rising edge is one frame tick
//   start_btn       raw mouse button level, synchronised here
//   player_1_score  current score of player 1 from the ball controller
//   player_2_score  current score of player 2 from the ball controller
//   ball_run        ball controller may integrate motion/collisions
//   ball_reset      one-cycle pulse: re-centre ball, zero velocity
//   serve_to        serve direction, 0 = toward player 1 side, 1 = toward player 2
//   score_clr       one-cycle pulse: clear both scores
//   state_out       0 IDLE, 1 SERVE, 2 PLAY, 3 GOAL, 4 OVER
//   winner          00 none, 01 player 1, 10 player 2, 11 both reached the win score

module game_flow_ctl #(
    parameter int WIN_SCORE         = 7,
    parameter int SERVE_FRAMES      = 60,
    parameter int GOAL_PAUSE_FRAMES = 120
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       vblnk_in,
    input  logic       start_btn,
    input  logic [3:0] player_1_score,
    input  logic [3:0] player_2_score,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       serve_to,
    output logic       score_clr,
    output logic [2:0] state_out,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_GOAL  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [3:0] WIN_LVL    = 4'(WIN_SCORE);
    // The transition fires on the tick that would bring the count to the limit,
    // so compare against limit-1 while that tick is present.
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] GOAL_LAST  = 8'(GOAL_PAUSE_FRAMES - 1);

    state_t     state;
    state_t     state_nxt;

    logic       btn_s1;
    logic       btn_s2;
    logic       btn_d;
    logic       press;

    logic       vblnk_q;
    logic       frame_tick;
    logic [7:0] frame_cnt;

    logic [3:0] p1_hist;
    logic [3:0] p2_hist;
    logic       p1_chg;
    logic       p2_chg;
    logic       score_chg;
    logic       hist_load;
    logic       p1_win;
    logic       p2_win;
    logic       serve_done;
    logic       pause_done;

    logic       ball_reset_nxt;
    logic       score_clr_nxt;
    logic       serve_to_nxt;
    logic [1:0] winner_nxt;

    // Button: two-flop synchroniser plus an edge register, so a held button
    // produces exactly one press.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            btn_d  <= 1'b0;
        end else begin
            btn_s1 <= start_btn;
            btn_s2 <= btn_s1;
            btn_d  <= btn_s2;
        end
    end

    assign press = btn_s2 & ~btn_d;

    // vblnk comes from our own timing chain, so no synchroniser; a held-high
    // vblnk yields a single tick.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            vblnk_q    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vblnk_q    <= vblnk_in;
            frame_tick <= vblnk_in & ~vblnk_q;
        end
    end

    assign p1_chg     = (player_1_score != p1_hist);
    assign p2_chg     = (player_2_score != p2_hist);
    assign score_chg  = p1_chg | p2_chg;
    assign p1_win     = (player_1_score >= WIN_LVL);
    assign p2_win     = (player_2_score >= WIN_LVL);
    assign serve_done = frame_tick & (frame_cnt >= SERVE_LAST);
    assign pause_done = frame_tick & (frame_cnt >= GOAL_LAST);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ball_reset_nxt = 1'b0;
        score_clr_nxt  = 1'b0;
        serve_to_nxt   = serve_to;
        winner_nxt     = winner;
        case (state)
            S_IDLE: begin
                if (press) begin
                    state_nxt      = S_SERVE;
                    ball_reset_nxt = 1'b1;
                    score_clr_nxt  = 1'b1;
                    serve_to_nxt   = 1'b0;
                end
            end
            S_SERVE: begin
                if (serve_done) begin
                    state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (score_chg) begin
                    state_nxt    = S_GOAL;
                    // The side that conceded receives the serve; a simultaneous
                    // double change falls back to player 1's side.
                    serve_to_nxt = p1_chg & ~p2_chg;
                end
            end
            S_GOAL: begin
                if (pause_done) begin
                    if (p1_win | p2_win) begin
                        state_nxt  = S_OVER;
                        winner_nxt = {p2_win, p1_win};
                    end else begin
                        state_nxt      = S_SERVE;
                        ball_reset_nxt = 1'b1;
                    end
                end
            end
            S_OVER: begin
                if (press) begin
                    state_nxt      = S_SERVE;
                    ball_reset_nxt = 1'b1;
                    score_clr_nxt  = 1'b1;
                    serve_to_nxt   = 1'b0;
                    winner_nxt     = 2'b00;
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                serve_to_nxt = 1'b0;
                winner_nxt   = 2'b00;
            end
        endcase
    end

    // Frame counter restarts on every state change and saturates at 255.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (state_nxt != state) begin
            frame_cnt <= 8'd0;
        end else if (frame_tick && (frame_cnt != 8'hFF)) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Outside PLAY the history tracks the inputs so score clears and edits
    // never look like goals; inside PLAY it only moves on the detected change,
    // so one goal produces one GOAL entry.
    assign hist_load = (state != S_PLAY) | score_chg;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            p1_hist <= 4'd0;
            p2_hist <= 4'd0;
        end else if (hist_load) begin
            p1_hist <= player_1_score;
            p2_hist <= player_2_score;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            ball_run   <= 1'b0;
            ball_reset <= 1'b0;
            score_clr  <= 1'b0;
            serve_to   <= 1'b0;
            winner     <= 2'b00;
        end else begin
            ball_run   <= (state_nxt == S_PLAY);
            ball_reset <= ball_reset_nxt;
            score_clr  <= score_clr_nxt;
            serve_to   <= serve_to_nxt;
            winner     <= winner_nxt;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_game_flow_ctl.sv
// Purpose : bench for game_flow_ctl; expected state entries are queued as stimulus is driven.
// Latency : a negedge monitor pops one entry per observed state change and compares outputs.
// Backpr. : none; the bench drives fixed cycle counts and a watchdog bounds the run.

module tb_game_flow_ctl;

    logic       clk_in;
    logic       rst;
    logic       vblnk_in;
    logic       start_btn;
    logic [3:0] player_1_score;
    logic [3:0] player_2_score;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_to;
    logic       score_clr;
    logic [2:0] state_out;
    logic [1:0] winner;

    typedef struct packed {
        logic [2:0] st;
        logic       run;
        logic       srv;
        logic [1:0] win;
        logic       rst_p;
        logic       clr_p;
    } exp_t;

    exp_t sb[$];
    int   tests_run   = 0;
    int   tests_fail  = 0;
    int   exp_pulses  = 0;
    int   seen_pulses = 0;

    game_flow_ctl #(
        .WIN_SCORE        (7),
        .SERVE_FRAMES     (60),
        .GOAL_PAUSE_FRAMES(120)
    ) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .vblnk_in      (vblnk_in),
        .start_btn     (start_btn),
        .player_1_score(player_1_score),
        .player_2_score(player_2_score),
        .ball_run      (ball_run),
        .ball_reset    (ball_reset),
        .serve_to      (serve_to),
        .score_clr     (score_clr),
        .state_out     (state_out),
        .winner        (winner)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_entry(input logic [2:0] st, input logic srv, input logic [1:0] win,
                                input logic rp, input logic cp);
        exp_t e;
        e.st    = st;
        e.run   = (st == 3'd2);
        e.srv   = srv;
        e.win   = win;
        e.rst_p = rp;
        e.clr_p = cp;
        sb.push_back(e);
        if (rp) exp_pulses++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic frame();
        vblnk_in = 1'b1;
        cyc(2);
        vblnk_in = 1'b0;
        cyc(2);
    endtask

    task automatic frame_long();
        vblnk_in = 1'b1;
        cyc(100);
        vblnk_in = 1'b0;
        cyc(2);
    endtask

    task automatic press(input int hold);
        start_btn = 1'b1;
        cyc(hold);
        start_btn = 1'b0;
        cyc(4);
    endtask

    task automatic goal_to_serve(input logic srv);
        repeat (119) frame();
        chk_val("goal_119", state_out, 3);
        expect_entry(3'd1, srv, 2'b00, 1'b1, 1'b0);
        frame();
        chk_val("goal_exit", state_out, 1);
    endtask

    task automatic serve_to_play(input logic srv);
        expect_entry(3'd2, srv, 2'b00, 1'b0, 1'b0);
        repeat (60) frame();
        chk_val("play_entry", state_out, 2);
    endtask

    // Monitor: every state change must match the head of the queue; pulses
    // outside a state change are stray.
    initial begin
        logic [2:0] prev_st;
        exp_t       e;
        prev_st = 3'd0;
        forever begin
            @(negedge clk_in);
            if (ball_reset === 1'b1) seen_pulses++;
            if (state_out !== prev_st) begin
                if (sb.size() == 0) begin
                    chk_val("unexp_trans", 32'(state_out), 32'(prev_st));
                end else begin
                    e = sb.pop_front();
                    chk_val("sb_state",      32'(state_out),  32'(e.st));
                    chk_val("sb_ball_run",   32'(ball_run),   32'(e.run));
                    chk_val("sb_serve_to",   32'(serve_to),   32'(e.srv));
                    chk_val("sb_winner",     32'(winner),     32'(e.win));
                    chk_val("sb_ball_reset", 32'(ball_reset), 32'(e.rst_p));
                    chk_val("sb_score_clr",  32'(score_clr),  32'(e.clr_p));
                end
                prev_st = state_out;
            end else if (ball_reset || score_clr) begin
                chk_val("stray_pulse", 32'({ball_reset, score_clr}), 32'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        vblnk_in       = 1'b0;
        start_btn      = 1'b0;
        player_1_score = 4'd0;
        player_2_score = 4'd0;
        cyc(3);
        chk_val("rst_state",      32'(state_out),  32'd0);
        chk_val("rst_ball_run",   32'(ball_run),   32'd0);
        chk_val("rst_ball_reset", 32'(ball_reset), 32'd0);
        chk_val("rst_score_clr",  32'(score_clr),  32'd0);
        chk_val("rst_serve_to",   32'(serve_to),   32'd0);
        chk_val("rst_winner",     32'(winner),     32'd0);
        rst = 1'b0;
        cyc(5);

        // Start: button held well past the transition triggers once.
        expect_entry(3'd1, 1'b0, 2'b00, 1'b1, 1'b1);
        press(20);
        chk_val("idle_to_serve", state_out, 1);
        // Held-high vblnk counts as a single frame.
        frame_long();
        repeat (58) frame();
        chk_val("serve_59", state_out, 1);
        expect_entry(3'd2, 1'b0, 2'b00, 1'b0, 1'b0);
        frame();
        chk_val("serve_60", state_out, 2);
        chk_val("play_run", ball_run, 1);
        press(8);
        chk_val("play_press_ign", state_out, 2);

        // Player 2 scores: serve toward player 1 side.
        expect_entry(3'd3, 1'b0, 2'b00, 1'b0, 1'b0);
        player_2_score = 4'd1;
        cyc(2);
        chk_val("goal_p2", state_out, 3);
        chk_val("goal_run", ball_run, 0);
        press(8);
        goal_to_serve(1'b0);
        serve_to_play(1'b0);
        cyc(10);
        chk_val("no_regoal", state_out, 2);

        // Player 1 scores alone: serve toward player 2 side.
        expect_entry(3'd3, 1'b1, 2'b00, 1'b0, 1'b0);
        player_1_score = 4'd1;
        cyc(2);
        chk_val("serve_to_p1", serve_to, 1);
        goal_to_serve(1'b1);
        serve_to_play(1'b1);

        // Both change in one cycle: single GOAL, serve toward player 1.
        expect_entry(3'd3, 1'b0, 2'b00, 1'b0, 1'b0);
        player_1_score = 4'd2;
        player_2_score = 4'd2;
        cyc(2);
        chk_val("goal_both", state_out, 3);
        goal_to_serve(1'b0);
        // Score edits during SERVE are absorbed.
        cyc(3);
        player_1_score = 4'd6;
        serve_to_play(1'b0);

        // Player 1 reaches the win score.
        expect_entry(3'd3, 1'b1, 2'b00, 1'b0, 1'b0);
        player_1_score = 4'd7;
        cyc(2);
        repeat (119) frame();
        chk_val("win_goal_119", state_out, 3);
        expect_entry(3'd4, 1'b1, 2'b01, 1'b0, 1'b0);
        frame();
        chk_val("over_p1", state_out, 4);
        chk_val("winner_p1", winner, 1);
        cyc(20);
        chk_val("winner_held", winner, 1);
        expect_entry(3'd1, 1'b0, 2'b00, 1'b1, 1'b1);
        press(8);
        chk_val("restart_state", state_out, 1);
        chk_val("restart_winner", winner, 0);
        player_1_score = 4'd0;
        player_2_score = 4'd0;
        serve_to_play(1'b0);

        // Both reach the win score together.
        expect_entry(3'd3, 1'b0, 2'b00, 1'b0, 1'b0);
        player_1_score = 4'd7;
        player_2_score = 4'd7;
        cyc(2);
        repeat (119) frame();
        expect_entry(3'd4, 1'b0, 2'b11, 1'b0, 1'b0);
        frame();
        chk_val("winner_both", winner, 3);
        expect_entry(3'd1, 1'b0, 2'b00, 1'b1, 1'b1);
        press(8);
        player_1_score = 4'd0;
        player_2_score = 4'd0;
        serve_to_play(1'b0);

        // Asynchronous reset mid-PLAY.
        expect_entry(3'd0, 1'b0, 2'b00, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_val("arst_state",      32'(state_out),  32'd0);
        chk_val("arst_ball_run",   32'(ball_run),   32'd0);
        chk_val("arst_ball_reset", 32'(ball_reset), 32'd0);
        chk_val("arst_score_clr",  32'(score_clr),  32'd0);
        cyc(5);
        chk_val("arst_held", 32'(state_out), 32'd0);
        rst = 1'b0;
        cyc(20);
        chk_val("post_rst_idle", 32'(state_out), 32'd0);

        cyc(5);
        chk_val("sb_drained", 32'(sb.size()), 32'd0);
        chk_val("reset_pulses", 32'(seen_pulses), 32'(exp_pulses));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
